// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM state encoding and
// a small response classification helper. Used by master and slave.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RSP          = 3'd5
    } state_t;

    // Error responses are exactly the codes with bit 1 set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi4lite_master_if.sv
// Bundle of the command/response side and the AXI4-Lite bus of the master.
// master modport: the DUT view. slave modport: the environment view.
interface axi4lite_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // command side
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    // response side
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    // AXI4-Lite read channels
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    // AXI4-Lite write channels
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready
    );

endinterface

// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite master. Takes one command, runs the AW/W/B
// or AR/R exchange, and presents one response before accepting the next.
// All bus-facing valid/ready outputs decode from registered state only.
// Optional: define AXI4LITE_MASTER_ERRCNT_EN to add the err_count output,
// a saturating count of SLVERR/DECERR responses delivered.
module axi4lite_master
    import axi4lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              areset,
`ifdef AXI4LITE_MASTER_ERRCNT_EN
    axi4lite_master_if.master bus,
    output logic [15:0]       err_count
`else
    axi4lite_master_if.master bus
`endif
);

    state_t            r_state;
    state_t            w_next;

    // set on the first edge out of reset so cmd_ready stays low during reset
    logic              r_out_en;
    logic              r_aw_done;
    logic              r_w_done;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rsp_write;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [1:0]        r_rsp_resp;

    logic              w_cmd_ready;
    logic              w_awvalid;
    logic              w_wvalid;
    logic              w_bready;
    logic              w_arvalid;
    logic              w_rready;
    logic              w_rsp_valid;

    logic              w_cmd_hs;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_b_hs;
    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_rsp_hs;

    assign w_cmd_hs = bus.cmd_valid & w_cmd_ready;
    assign w_aw_hs  = w_awvalid & bus.awready;
    assign w_w_hs   = w_wvalid & bus.wready;
    assign w_b_hs   = w_bready & bus.bvalid;
    assign w_ar_hs  = w_arvalid & bus.arready;
    assign w_r_hs   = w_rready & bus.rvalid;
    assign w_rsp_hs = w_rsp_valid & bus.rsp_ready;

    // state register
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_cmd_hs) begin
                    w_next = bus.cmd_write ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (w_b_hs) begin
                    w_next = RSP;
                end
            end
            RD_ADDR: begin
                if (w_ar_hs) begin
                    w_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (w_r_hs) begin
                    w_next = RSP;
                end
            end
            RSP: begin
                if (w_rsp_hs) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // handshake outputs, decoded from state and done flags only
    always_comb begin
        w_cmd_ready = 1'b0;
        w_awvalid   = 1'b0;
        w_wvalid    = 1'b0;
        w_bready    = 1'b0;
        w_arvalid   = 1'b0;
        w_rready    = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            IDLE:         w_cmd_ready = r_out_en;
            WR_ADDR_DATA: begin
                w_awvalid = ~r_aw_done;
                w_wvalid  = ~r_w_done;
            end
            WR_RESP:      w_bready    = 1'b1;
            RD_ADDR:      w_arvalid   = 1'b1;
            RD_DATA:      w_rready    = 1'b1;
            RSP:          w_rsp_valid = 1'b1;
            default:      ;
        endcase
    end

    // reset-release flag gating cmd_ready
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_out_en <= 1'b0;
        end else begin
            r_out_en <= 1'b1;
        end
    end

    // command capture, per-channel done flags and response capture
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= RESP_OKAY;
        end else begin
            if (w_cmd_hs) begin
                r_addr    <= bus.cmd_addr;
                r_wdata   <= bus.cmd_wdata;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
            if (w_b_hs) begin
                r_rsp_write <= 1'b1;
                r_rsp_rdata <= '0;
                r_rsp_resp  <= bus.bresp;
            end
            if (w_r_hs) begin
                r_rsp_write <= 1'b0;
                r_rsp_rdata <= bus.rdata;
                r_rsp_resp  <= bus.rresp;
            end
        end
    end

`ifdef AXI4LITE_MASTER_ERRCNT_EN
    logic [15:0] r_err_count;

    // count error responses as they are delivered, saturating at all-ones
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_err_count <= '0;
        end else if (w_rsp_hs && resp_is_err(r_rsp_resp) && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`endif

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.awvalid   = w_awvalid;
    assign bus.wvalid    = w_wvalid;
    assign bus.bready    = w_bready;
    assign bus.arvalid   = w_arvalid;
    assign bus.rready    = w_rready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.awaddr    = r_addr;
    assign bus.araddr    = r_addr;
    assign bus.wdata     = r_wdata;
    assign bus.rsp_write = r_rsp_write;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_resp  = r_rsp_resp;

endmodule

// File: tb/tb_axi4lite_master.sv
// Scoreboard bench for axi4lite_master: directed commands push expected
// responses, a negedge monitor pops and compares on each response handshake
// and checks channel stability, timing and single-outstanding behaviour.
// Define AXI4LITE_MASTER_ERRCNT_EN to also check err_count.
module tb_axi4lite_master;
    import axi4lite_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    axi4lite_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef AXI4LITE_MASTER_ERRCNT_EN
    logic [15:0] err_count;
    axi4lite_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .aclk(aclk), .areset(areset), .bus(bus), .err_count(err_count));
`else
    axi4lite_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .aclk(aclk), .areset(areset), .bus(bus));
`endif

    typedef struct packed {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb_q[$];
    int   vecs = 0;
    int   errs = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // slave configuration
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, rs_dly = 0;
    logic        b_hold = 1'b0;
    logic [1:0]  s_bresp = RESP_OKAY;
    logic [1:0]  s_rresp = RESP_OKAY;
    logic [31:0] s_rdata = 32'h0;

    // slave / response sink: drives ready/valid just after each rising edge
    initial begin
        int aw_w, w_w, ar_w, rs_w;
        aw_w = 0; w_w = 0; ar_w = 0; rs_w = 0;
        bus.awready = 0; bus.wready = 0; bus.arready = 0;
        bus.bvalid = 0; bus.bresp = 0; bus.rvalid = 0; bus.rresp = 0; bus.rdata = 0;
        bus.rsp_ready = 1;
        forever begin
            @(posedge aclk); #1;
            if (bus.awvalid) begin
                if (aw_w >= aw_dly) bus.awready = 1; else begin bus.awready = 0; aw_w++; end
            end else begin bus.awready = 0; aw_w = 0; end
            if (bus.wvalid) begin
                if (w_w >= w_dly) bus.wready = 1; else begin bus.wready = 0; w_w++; end
            end else begin bus.wready = 0; w_w = 0; end
            if (bus.arvalid) begin
                if (ar_w >= ar_dly) bus.arready = 1; else begin bus.arready = 0; ar_w++; end
            end else begin bus.arready = 0; ar_w = 0; end
            bus.bvalid = bus.bready & ~b_hold;
            bus.bresp  = s_bresp;
            bus.rvalid = bus.rready;
            bus.rresp  = s_rresp;
            bus.rdata  = s_rdata;
            if (bus.rsp_valid) begin
                if (rs_w >= rs_dly) bus.rsp_ready = 1; else begin bus.rsp_ready = 0; rs_w++; end
            end else begin bus.rsp_ready = (rs_dly == 0); rs_w = 0; end
        end
    end

    // monitor state
    int cyc = 0, acc_cyc = 0, aw_cyc = 0, w_cyc = 0, ar_cyc = 0;
    int b_first = -1, lat = 0, stall_cnt = 0, acc_total = 0, outstanding = 0;
    logic [31:0] lat_addr = 0, lat_wdata = 0;
    logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic        p_rspv = 0, p_rspr = 0, p_rspw = 0;
    logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0, p_rdata = 0;
    logic [1:0]  p_resp = 0;

    // monitor: samples on the falling edge, scoreboard pop on rsp handshake
    always @(negedge aclk) begin
        exp_t e;
        logic wr_any, rd_any;
        cyc++;
        if (areset) begin
            outstanding = 0;
            p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
            p_rspv = 0; p_rspr = 0;
        end else begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                chk("single_outstanding", outstanding, 0);
                outstanding++; acc_total++; acc_cyc = cyc;
                lat_addr = bus.cmd_addr; lat_wdata = bus.cmd_wdata;
                b_first = -1; stall_cnt = 0;
            end
            if (p_awv && !p_awr) begin
                chk("awvalid_held", bus.awvalid, 1); chk("awaddr_stable", bus.awaddr, p_awaddr);
            end
            if (p_awv && p_awr) chk("awvalid_drop", bus.awvalid, 0);
            if (p_wv && !p_wr) begin
                chk("wvalid_held", bus.wvalid, 1); chk("wdata_stable", bus.wdata, p_wdata);
            end
            if (p_wv && p_wr) chk("wvalid_drop", bus.wvalid, 0);
            if (p_arv && !p_arr) begin
                chk("arvalid_held", bus.arvalid, 1); chk("araddr_stable", bus.araddr, p_araddr);
            end
            if (p_arv && p_arr) chk("arvalid_drop", bus.arvalid, 0);
            if (bus.awvalid && bus.awready) begin aw_cyc = cyc; chk("awaddr", bus.awaddr, lat_addr); end
            if (bus.wvalid && bus.wready) begin w_cyc = cyc; chk("wdata", bus.wdata, lat_wdata); end
            if (bus.arvalid && bus.arready) begin ar_cyc = cyc; chk("araddr", bus.araddr, lat_addr); end
            if (bus.bready) begin
                if (b_first < 0) b_first = cyc;
                chk("bready_after_aw_w", bus.awvalid | bus.wvalid, 0);
            end
            wr_any = bus.awvalid | bus.wvalid | bus.bready;
            rd_any = bus.arvalid | bus.rready;
            if (wr_any || rd_any) chk("axi_overlap", wr_any & rd_any, 0);
            if (p_rspv && p_rspr) chk("rsp_valid_drop", bus.rsp_valid, 0);
            if (bus.rsp_valid) begin
                chk("cmd_ready_in_rsp", bus.cmd_ready, 0);
                if (!p_rspv) lat = cyc - acc_cyc;
                if (p_rspv && !p_rspr) begin
                    chk("rsp_write_stable", bus.rsp_write, p_rspw);
                    chk("rsp_rdata_stable", bus.rsp_rdata, p_rdata);
                    chk("rsp_resp_stable", bus.rsp_resp, p_resp);
                end
                if (!bus.rsp_ready) stall_cnt++;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                outstanding--;
                if (sb_q.size() == 0) begin
                    vecs++; errs++;
                    $display("FAIL unexpected_rsp: got rsp_valid expected none");
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_write", bus.rsp_write, e.write);
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_resp", bus.rsp_resp, e.resp);
                end
            end
            p_awv = bus.awvalid; p_awr = bus.awready; p_awaddr = bus.awaddr;
            p_wv = bus.wvalid; p_wr = bus.wready; p_wdata = bus.wdata;
            p_arv = bus.arvalid; p_arr = bus.arready; p_araddr = bus.araddr;
            p_rspv = bus.rsp_valid; p_rspr = bus.rsp_ready; p_rspw = bus.rsp_write;
            p_rdata = bus.rsp_rdata; p_resp = bus.rsp_resp;
        end
    end

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic [1:0] rr, input bit keep);
        exp_t e;
        bit ok;
        ok = 0;
        e.write = w; e.rdata = er; e.resp = rr;
        sb_q.push_back(e);
        @(posedge aclk); #1;
        bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_valid = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (bus.cmd_ready) begin ok = 1; break; end
        end
        if (!ok) begin vecs++; errs++; $display("FAIL cmd_accept_timeout: got no accept expected accept"); end
        @(posedge aclk); #1;
        if (!keep) bus.cmd_valid = 0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge aclk);
            if (sb_q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin vecs++; errs++; $display("FAIL rsp_timeout: got %0d pending expected 0", sb_q.size()); end
        @(posedge aclk); @(negedge aclk);
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_valids"}, {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, bus.rsp_valid}, 0);
        chk({nm, "_cmd_ready"}, bus.cmd_ready, 0);
    endtask

    initial begin
        int a0;
        bit ok;
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;

        // reset state
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk_quiet("rst");
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_resp", bus.rsp_resp, 0);
        chk("rst_rsp_write", bus.rsp_write, 0);
        chk("rst_awaddr", bus.awaddr, 0);
        chk("rst_wdata", bus.wdata, 0);
`ifdef AXI4LITE_MASTER_ERRCNT_EN
        chk("rst_err_count", err_count, 0);
`endif
        @(posedge aclk); #1 areset = 0;
        @(posedge aclk); @(negedge aclk);
        chk("cmd_ready_after_rst", bus.cmd_ready, 1);

        // write, always-ready slave
        send(1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, RESP_OKAY, 0);
        wait_done();
        chk("t1_latency", lat, 3);
        chk("t1_aw_cyc", aw_cyc - acc_cyc, 1);
        chk("t1_w_cyc", w_cyc - acc_cyc, 1);

        // write, wready 4 cycles after awready
        w_dly = 4;
        send(1, 32'h0000_0014, 32'hDEAD_BEEF, 32'h0, RESP_OKAY, 0);
        wait_done();
        chk("t2_w_after_aw", w_cyc - aw_cyc, 4);
        chk("t2_bready_after_w", b_first - w_cyc, 1);
        w_dly = 0;

        // read, arready delayed 2 cycles
        ar_dly = 2; s_rdata = 32'h1234_5678; s_rresp = RESP_OKAY;
        send(0, 32'h0000_0020, 32'h0, 32'h1234_5678, RESP_OKAY, 0);
        wait_done();
        chk("t3_ar_cyc", ar_cyc - acc_cyc, 3);
        ar_dly = 0;

        // read SLVERR with rsp_ready held low 5 cycles
        s_rdata = 32'hAAAA_5555; s_rresp = RESP_SLVERR; rs_dly = 5;
`ifdef AXI4LITE_MASTER_ERRCNT_EN
        chk("t4_err_before", err_count, 0);
`endif
        send(0, 32'h0000_0024, 32'h0, 32'hAAAA_5555, RESP_SLVERR, 0);
        wait_done();
        chk("t4_stall_cycles", stall_cnt, 5);
`ifdef AXI4LITE_MASTER_ERRCNT_EN
        chk("t4_err_after", err_count, 1);
`endif
        rs_dly = 0;

        // reset while waiting in WR_RESP
        b_hold = 1;
        send(1, 32'h0000_0030, 32'hCAFE_F00D, 32'h0, RESP_OKAY, 0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (bus.bready) begin ok = 1; break; end
        end
        chk("t5_reached_wr_resp", ok, 1);
        @(posedge aclk); #1 areset = 1;
        sb_q.delete();
        @(posedge aclk); @(negedge aclk);
        chk_quiet("t5_rst");
        @(posedge aclk); #1 areset = 0;
        b_hold = 0; s_rresp = RESP_EXOKAY; s_rdata = 32'h0BAD_F00D;
        send(0, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, RESP_EXOKAY, 0);
        wait_done();
        chk("t5_read_latency", lat, 3);
`ifdef AXI4LITE_MASTER_ERRCNT_EN
        chk("t5_err_cleared", err_count, 0);
`endif

        // three back-to-back writes with cmd_valid held high
        s_bresp = RESP_DECERR;
        a0 = acc_total;
        send(1, 32'h0000_0100, 32'h1111_1111, 32'h0, RESP_DECERR, 1);
        send(1, 32'h0000_0104, 32'h2222_2222, 32'h0, RESP_DECERR, 1);
        send(1, 32'h0000_0108, 32'h3333_3333, 32'h0, RESP_DECERR, 0);
        wait_done();
        chk("t6_accepts", acc_total - a0, 3);
`ifdef AXI4LITE_MASTER_ERRCNT_EN
        chk("t6_err_count", err_count, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/axi4lite_master.md
AXI4LITE_MASTER -- requirements
Module: axi4lite_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have ports: aclk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have ports: areset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1=write, 0=read); cmd_addr in ADDR_W; cmd_wdata in DATA_W.
REQ-006 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_write out 1; rsp_rdata out DATA_W; rsp_resp out 2.
REQ-007 SHALL have AXI4-Lite master ports: araddr out ADDR_W; arvalid out; arready in; rdata in DATA_W; rresp in 2; rvalid in; rready out; awaddr out ADDR_W; awvalid out; awready in; wdata out DATA_W; wvalid out; wready in; bresp in 2; bvalid in; bready out.

Function
REQ-008 SHALL implement FSM states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
REQ-009 SHALL drive cmd_ready=1 only in IDLE; command accepted on cmd_valid&cmd_ready.
REQ-010 SHALL register cmd_addr/cmd_wdata on acceptance; awaddr/araddr/wdata stay stable until their handshake completes.
REQ-011 Write accept: next state WR_ADDR_DATA; awvalid and wvalid both asserted in the first cycle of that state.
REQ-012 awvalid SHALL drop the cycle after awvalid&awready; wvalid SHALL drop the cycle after wvalid&wready; the two handshakes are independent, in either order or the same cycle.
REQ-013 SHALL enter WR_RESP the cycle after both AW and W handshakes have completed; bready=1 only in WR_RESP.
REQ-014 Read accept: next state RD_ADDR with arvalid=1; after arvalid&arready, go to RD_DATA with rready=1 only in RD_DATA.
REQ-015 On bvalid&bready or rvalid&rready, SHALL capture resp (and rdata for reads; rsp_rdata=0 for writes), set rsp_write, and enter RSP.
REQ-016 In RSP, rsp_valid=1 with stable rsp_* until rsp_valid&rsp_ready, then return to IDLE; next command is accepted no earlier than the following cycle.
REQ-017 Valid outputs SHALL never wait on the corresponding ready (no combinational ready->valid path); no input->output combinational path anywhere.
REQ-018 Exactly one transaction outstanding; with always-ready slave: accept at T, AW/W handshake T+1, B handshake T+2, rsp_valid T+3.
REQ-019 rresp/bresp SHALL pass through unmodified (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR).

Reset
REQ-020 While areset=1: state=IDLE, all valid/ready outputs 0, addr/data/rsp registers 0.
REQ-021 Reset mid-transaction SHALL abandon it silently at the next edge; no response is generated for it.
REQ-022 cmd_ready SHALL be 0 during reset and 1 in the first cycle after release.

Configuration
REQ-023 Macro AXI4LITE_MASTER_ERRCNT_EN defined: adds output err_count (16 bits), incremented once per completed response with resp[1]=1, saturating at 0xFFFF, cleared by reset.
REQ-024 Macro undefined: no err_count port or counter logic; all other behaviour identical.

Structure
REQ-025 Package axi4lite_pkg SHALL hold resp code constants (RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR) and the FSM state typedef, shared with the slave.
REQ-026 Single module; no sub-module (FSM plus registers only).

Verification
REQ-027 Write 0x0000_0010 <= 0xDEAD_BEEF, slave always ready, bresp=00 -> AW/W same cycle, rsp_valid 3 cycles after accept, rsp_write=1, rsp_resp=00.
REQ-028 Write with wready delayed 4 cycles after awready -> awvalid drops after its handshake, wvalid held stable with 0xDEAD_BEEF, bready only after W handshake.
REQ-029 Read 0x0000_0020, arready delayed 2 cycles, rdata=0x1234_5678 rresp=00 -> rsp_rdata=0x1234_5678, rsp_write=0.
REQ-030 Read with rresp=10 and rsp_ready low 5 cycles -> rsp held stable, cmd_ready=0 throughout; with ERRCNT_EN err_count 0->1.
REQ-031 Reset asserted while in WR_RESP -> next cycle all valids/readies 0, no rsp_valid; new read after release completes normally.
REQ-032 Back-to-back cmd_valid held high for 3 writes -> one accept per completed response, no overlapping AXI valids.
